// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus of the load/store sequencer.
// slave: the sequencer's view; master: the CPU datapath plus memory side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_din, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_din, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one byte/half/word access at a time against a
// word-addressed memory, with read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int unsigned READ_WAIT = 0,
  parameter int unsigned WAIT_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus_io
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT);

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    case (f3)
      3'b000:  r[{off, 3'b000} +: 8] = wdata[7:0];
      3'b001:  r[{off[1], 4'b0000} +: 16] = wdata[15:0];
      3'b010:  r = wdata;
      default: r = word;
    endcase
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  cnt_q, cnt_d;
  logic               write_q;
  logic [2:0]         funct3_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rbuf_q;

  logic               illegal_s;
  logic               misaligned_s;
  logic               accept_s;
  logic               read_done_s;

  logic               req_ready_s;
  logic               resp_valid_s;
  logic               resp_err_s;
  logic [31:0]        resp_rdata_s;
  logic [31:0]        mem_addr_s;
  logic [31:0]        mem_din_s;
  logic               mem_read_s;
  logic               mem_write_s;

  // Classify the incoming request and find the end of the read window
  always_comb begin
    illegal_s = (bus_io.req_funct3 == 3'b011) || (bus_io.req_funct3 == 3'b110) ||
                (bus_io.req_funct3 == 3'b111) ||
                (bus_io.req_write && bus_io.req_funct3[2]);
    misaligned_s = ((bus_io.req_funct3[1:0] == 2'b01) && bus_io.req_addr[0]) ||
                   ((bus_io.req_funct3 == 3'b010) && (bus_io.req_addr[1:0] != 2'b00));
    accept_s    = (state_q == ST_IDLE) && bus_io.req_valid;
    read_done_s = (state_q == ST_READ) && (cnt_q == WAIT_LAST);
  end

  // Next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_io.req_valid) begin
          if (illegal_s || misaligned_s) begin
            state_d = ST_ERR;
          end else if (bus_io.req_write && (bus_io.req_funct3 == 3'b010)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (read_done_s) begin
          cnt_d   = '0;
          state_d = write_q ? ST_WRITE : ST_RESP;
        end else begin
          cnt_d   = cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, counter and request/read-data latches
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rbuf_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_s) begin
        write_q  <= bus_io.req_write;
        funct3_q <= bus_io.req_funct3;
        addr_q   <= bus_io.req_addr;
        wdata_q  <= bus_io.req_wdata;
      end
      if (read_done_s) begin
        rbuf_q <= bus_io.mem_dout;
      end
    end
  end

  // Moore output decode; reset forces the idle view before the first edge
  always_comb begin
    req_ready_s  = 1'b0;
    resp_valid_s = 1'b0;
    resp_err_s   = 1'b0;
    resp_rdata_s = 32'd0;
    mem_addr_s   = 32'd0;
    mem_din_s    = 32'd0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    if (reset) begin
      req_ready_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: req_ready_s = 1'b1;
        ST_READ: begin
          mem_read_s = 1'b1;
          mem_addr_s = {addr_q[31:2], 2'b00};
        end
        ST_WRITE: begin
          mem_write_s = 1'b1;
          mem_addr_s  = {addr_q[31:2], 2'b00};
          mem_din_s   = merge_store(rbuf_q, wdata_q, funct3_q, addr_q[1:0]);
        end
        ST_RESP: begin
          resp_valid_s = 1'b1;
          resp_rdata_s = write_q ? 32'd0 : load_extend(rbuf_q, funct3_q, addr_q[1:0]);
        end
        ST_ERR: begin
          resp_valid_s = 1'b1;
          resp_err_s   = 1'b1;
        end
        default: req_ready_s = 1'b0;
      endcase
    end
  end

  assign bus_io.req_ready  = req_ready_s;
  assign bus_io.resp_valid = resp_valid_s;
  assign bus_io.resp_err   = resp_err_s;
  assign bus_io.resp_rdata = resp_rdata_s;
  assign bus_io.mem_addr   = mem_addr_s;
  assign bus_io.mem_din    = mem_din_s;
  assign bus_io.mem_read   = mem_read_s;
  assign bus_io.mem_write  = mem_write_s;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: dut0 with READ_WAIT=0, dut1 with READ_WAIT=2, each on its
// own word memory with 0x100 preloaded to 0x8899AABB.
module tb_mem_access_unit;
  logic clk;
  logic reset;
  logic preload;
  logic sel;
  logic rv;
  logic wr;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  int checks;
  int failures;

  mem_access_unit_if if0 ();
  mem_access_unit_if if1 ();

  mem_access_unit #(.READ_WAIT(0), .WAIT_W(4)) dut0 (.clk(clk), .reset(reset), .bus_io(if0));
  mem_access_unit #(.READ_WAIT(2), .WAIT_W(4)) dut1 (.clk(clk), .reset(reset), .bus_io(if1));

  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];

  assign if0.req_valid  = rv & ~sel;
  assign if1.req_valid  = rv & sel;
  assign if0.req_write  = wr;
  assign if1.req_write  = wr;
  assign if0.req_funct3 = f3;
  assign if1.req_funct3 = f3;
  assign if0.req_addr   = addr;
  assign if1.req_addr   = addr;
  assign if0.req_wdata  = wdata;
  assign if1.req_wdata  = wdata;
  assign if0.mem_dout   = mem0[if0.mem_addr[9:2]];
  assign if1.mem_dout   = mem1[if1.mem_addr[9:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= 32'd0;
        mem1[i] <= 32'd0;
      end
      mem0[64] <= 32'h8899AABB;
      mem1[64] <= 32'h8899AABB;
    end else begin
      if (if0.mem_write) mem0[if0.mem_addr[9:2]] <= if0.mem_din;
      if (if1.mem_write) mem1[if1.mem_addr[9:2]] <= if1.mem_din;
    end
  end

  logic        o_ready, o_rvalid, o_err, o_rd, o_wr;
  logic [31:0] o_rdata, o_maddr, o_din;
  assign o_ready  = sel ? if1.req_ready  : if0.req_ready;
  assign o_rvalid = sel ? if1.resp_valid : if0.resp_valid;
  assign o_err    = sel ? if1.resp_err   : if0.resp_err;
  assign o_rdata  = sel ? if1.resp_rdata : if0.resp_rdata;
  assign o_maddr  = sel ? if1.mem_addr   : if0.mem_addr;
  assign o_din    = sel ? if1.mem_din    : if0.mem_din;
  assign o_rd     = sel ? if1.mem_read   : if0.mem_read;
  assign o_wr     = sel ? if1.mem_write  : if0.mem_write;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, watch a fixed window, then compare the whole transaction
  task automatic run(input logic s, input logic w, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d,
                     input int exp_cyc, input logic exp_err, input logic [31:0] exp_rdata,
                     input int exp_rd, input int exp_wr, input logic [31:0] exp_din,
                     input int pulse_at, input string tag);
    int resp_cyc, nresp, nrd, nwr;
    logic got_err, addr_ok, overlap;
    logic [31:0] got_rdata, got_din;
    resp_cyc = 0; nresp = 0; nrd = 0; nwr = 0;
    got_err = 1'b0; got_rdata = 32'd0; got_din = 32'd0;
    addr_ok = 1'b1; overlap = 1'b0;
    sel = s; wr = w; f3 = f; addr = a; wdata = d;
    #1;
    chk({tag, ".ready"}, {31'd0, o_ready}, 32'd1);
    rv = 1'b1;
    tick();
    rv = 1'b0;
    for (int c = 1; c <= exp_cyc + 6; c++) begin
      rv = (c == pulse_at);
      if (o_rd) begin
        nrd++;
        if (o_maddr !== {a[31:2], 2'b00}) addr_ok = 1'b0;
      end
      if (o_wr) begin
        nwr++;
        got_din = o_din;
        if (o_maddr !== {a[31:2], 2'b00}) addr_ok = 1'b0;
      end
      if (o_rd && o_wr) overlap = 1'b1;
      if (o_rvalid) begin
        nresp++;
        if (resp_cyc == 0) begin
          resp_cyc  = c;
          got_err   = o_err;
          got_rdata = o_rdata;
        end
      end
      tick();
    end
    rv = 1'b0;
    chk({tag, ".resp_cycle"}, resp_cyc, exp_cyc);
    chk({tag, ".resp_count"}, nresp, 32'd1);
    chk({tag, ".err"}, {31'd0, got_err}, {31'd0, exp_err});
    chk({tag, ".rdata"}, got_rdata, exp_rdata);
    chk({tag, ".reads"}, nrd, exp_rd);
    chk({tag, ".writes"}, nwr, exp_wr);
    if (exp_wr != 0) chk({tag, ".din"}, got_din, exp_din);
    chk({tag, ".addr"}, {31'd0, addr_ok}, 32'd1);
    chk({tag, ".overlap"}, {31'd0, overlap}, 32'd0);
  endtask

  initial begin
    int nwr_abort, nresp_abort;
    checks = 0; failures = 0;
    sel = 1'b0; rv = 1'b0; wr = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    reset = 1'b1; preload = 1'b1;
    tick(); tick(); tick();
    chk("reset.ready",  {31'd0, o_ready},  32'd1);
    chk("reset.rvalid", {31'd0, o_rvalid}, 32'd0);
    chk("reset.mread",  {31'd0, o_rd},     32'd0);
    chk("reset.maddr",  o_maddr,           32'd0);
    reset = 1'b0; preload = 1'b0;
    tick();

    run(1'b0, 1'b0, 3'b000, 32'h101, 32'd0, 2, 1'b0, 32'hFFFFFFAA, 1, 0, 32'd0, 0, "lb101");
    run(1'b0, 1'b0, 3'b100, 32'h103, 32'd0, 2, 1'b0, 32'h00000088, 1, 0, 32'd0, 0, "lbu103");
    run(1'b0, 1'b0, 3'b001, 32'h102, 32'd0, 2, 1'b0, 32'hFFFF8899, 1, 0, 32'd0, 0, "lh102");
    run(1'b0, 1'b0, 3'b010, 32'h100, 32'd0, 2, 1'b0, 32'h8899AABB, 1, 0, 32'd0, 0, "lw100");
    run(1'b0, 1'b1, 3'b000, 32'h102, 32'h12345655, 3, 1'b0, 32'd0, 1, 1, 32'h8855AABB, 0, "sb102");
    run(1'b0, 1'b0, 3'b010, 32'h100, 32'd0, 2, 1'b0, 32'h8855AABB, 1, 0, 32'd0, 0, "lw_after_sb");
    run(1'b0, 1'b0, 3'b101, 32'h100, 32'd0, 2, 1'b0, 32'h0000AABB, 1, 0, 32'd0, 0, "lhu100");
    run(1'b0, 1'b0, 3'b001, 32'h101, 32'd0, 1, 1'b1, 32'd0, 0, 0, 32'd0, 0, "lh101_mis");
    run(1'b0, 1'b1, 3'b010, 32'h102, 32'hDEADBEEF, 1, 1'b1, 32'd0, 0, 0, 32'd0, 0, "sw102_mis");
    run(1'b0, 1'b0, 3'b011, 32'h100, 32'd0, 1, 1'b1, 32'd0, 0, 0, 32'd0, 0, "f3_011");
    run(1'b0, 1'b1, 3'b100, 32'h100, 32'd0, 1, 1'b1, 32'd0, 0, 0, 32'd0, 0, "sbu_ill");

    // Half store aborted by reset while the read is in flight
    sel = 1'b0; wr = 1'b1; f3 = 3'b001; addr = 32'h100; wdata = 32'hFFFF0000;
    rv = 1'b1;
    tick();
    rv = 1'b0;
    chk("abort.in_read", {31'd0, o_rd}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort.ready_in_reset", {31'd0, o_ready}, 32'd1);
    chk("abort.mread_in_reset", {31'd0, o_rd}, 32'd0);
    nwr_abort = 0; nresp_abort = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (o_wr) nwr_abort++;
      if (o_rvalid) nresp_abort++;
    end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (o_wr) nwr_abort++;
      if (o_rvalid) nresp_abort++;
    end
    chk("abort.writes", nwr_abort, 32'd0);
    chk("abort.resps", nresp_abort, 32'd0);
    chk("abort.ready", {31'd0, o_ready}, 32'd1);
    chk("abort.mem_word", mem0[64], 32'h8855AABB);
    run(1'b0, 1'b0, 3'b010, 32'h100, 32'd0, 2, 1'b0, 32'h8855AABB, 1, 0, 32'd0, 0, "lw_after_abort");

    // Slow memory: three read cycles, stray req_valid during READ ignored
    run(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 4, 1'b0, 32'h8899AABB, 3, 0, 32'd0, 1, "rw2_lw100");
    run(1'b1, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, 5, 1'b0, 32'd0, 3, 1, 32'hBEEFAABB, 0, "rw2_sh102");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator-side load/store sequencer between the multi-cycle CPU datapath and the word-addressed data memory (async read, sync write, `mem_read`/`mem_write` strobes).
- Accepts one byte/half/word load or store request at a time.
- Drives word-aligned memory transactions, including read-modify-write for sub-word stores.
- Returns sign/zero-extended load data with a one-cycle response pulse.
- Flags misaligned or illegal accesses without touching memory.

Parameters:
READ_WAIT, 0, extra cycles `mem_read` is held before `mem_dout` is sampled (models slower memory; 0..15)
WAIT_W, 4, width of the wait counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present; sampled only in IDLE
req_ready  out  1  high only in IDLE
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data (low byte/half used for B/H)
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  valid with resp_valid; 1 = misaligned/illegal, no memory access done
resp_rdata  out  32  extended load data; 0 for stores and errors
mem_addr  out  32  {lat_addr[31:2],2'b00}; 0 in IDLE
mem_din  out  32  write word; 0 unless mem_write
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_dout  in  32  memory read data (combinational from memory)

Behaviour:
- Reset: synchronous, active-high, on clk. State <= IDLE, wait counter <= 0, all latches <= 0. While reset is high, every output is 0 except req_ready=1 (IDLE decode). Reset in any state aborts the access: no further `mem_write`, no resp_valid.
- FSM states: IDLE, READ, WRITE, RESP, ERR. Outputs are Moore-decoded from registered state and latches.
- IDLE: req_ready=1. On req_valid, latch write, funct3, addr and wdata.
  - Illegal if funct3 is in {011, 110, 111}, or if req_write with funct3[2]=1.
  - Misaligned if H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Illegal or misaligned -> ERR.
  - Load -> READ. Store word -> WRITE. Store byte/half -> READ.
  - req_valid is ignored in every other state.
- READ: mem_read=1, mem_addr is the aligned address. The counter increments each cycle.
  - When counter==READ_WAIT: capture mem_dout into rbuf, clear the counter.
  - Then go to RESP for a load, or WRITE for a sub-word store.
  - mem_read stays high for exactly READ_WAIT+1 cycles.
- WRITE: mem_write=1 for exactly one cycle, then RESP.
  - Word store: mem_din = wdata.
  - Byte store: mem_din = rbuf with lane addr[1:0] replaced by wdata[7:0].
  - Half store: mem_din = rbuf with lane addr[1] replaced by wdata[15:0].
- Lane mapping is little-endian: byte k occupies bits [8k+7:8k].
- RESP: resp_valid=1, resp_err=0, then IDLE.
  - Loads: resp_rdata is the selected lane extended to 32 bits; B/H sign-extend, BU/HU zero-extend, W passes through.
  - Stores: resp_rdata=0.
- ERR: resp_valid=1, resp_err=1, resp_rdata=0, then IDLE. mem_read/mem_write never assert for an errored request.
- Latency in cycles after the accept edge, with READ_WAIT=0:
  - Load: READ 1 cycle, resp_valid in cycle 2.
  - Store word: WRITE 1 cycle, resp_valid in cycle 2.
  - Sub-word store: READ, WRITE, resp_valid in cycle 3.
  - Error: resp_valid in cycle 1.
- Back-to-back: a new request can be accepted on the cycle after RESP/ERR. There is no bypass or overlap.
- mem_read and mem_write are never high in the same cycle.
- Addresses wrap naturally; no range check (memory decodes addr>>2).

Test Plan:
- Setup: mem word 0x100 = 0x8899AABB, READ_WAIT=0.
- LB @0x101 -> mem_read one cycle at mem_addr 0x100; resp_valid 2 cycles after accept; resp_rdata=0xFFFFFFAA, resp_err=0.
- LBU @0x103 -> 0x00000088. LH @0x102 -> 0xFFFF8899. LW @0x100 -> 0x8899AABB.
- SB @0x102 wdata 0x12345655 -> READ, then one-cycle mem_write with mem_din=0x8855AABB; resp_valid, resp_rdata=0. A subsequent LW @0x100 returns 0x8855AABB.
- LH @0x101, SW @0x102, and funct3=011 load -> each gives resp_valid=resp_err=1 one cycle after accept; mem_read and mem_write stay 0 throughout.
- SH @0x100 with reset asserted during READ -> mem_write never asserts; no resp_valid; req_ready=1 after reset; word 0x100 unchanged.
- Bench with READ_WAIT=2: LW @0x100 -> mem_read high exactly 3 cycles; resp_valid at cycle 4 with 0x8899AABB. req_valid pulsed during READ is ignored (no second response).
